// File: rtl/rainbow_light_pkg.sv
// Shared types and helpers for the rainbow-light bus.
// The controller bench also uses the rotate and one-hot helpers.
package rainbow_light_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_TRACK
  } state_t;

  // Rotate left by one within the low w bits; bits above w are zero.
  function automatic logic [MAX_W-1:0] rotl1(
    input logic [MAX_W-1:0] v,
    input int               w
  );
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  function automatic logic is_onehot(
    input logic [MAX_W-1:0] v
  );
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/rainbow_light_monitor_onehot_to_bin.sv
// One-hot to binary index encoder.
// Pure combinational; a zero input gives index 0.
module onehot_to_bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         oh_i,
  output logic [$clog2(WIDTH)-1:0] bin_o
);

  localparam int BW = $clog2(WIDTH);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh_i[i]) bin_o = bin_o | BW'(i);
    end
  end

endmodule

// File: rtl/rainbow_light_monitor.sv
// Receive-side checker for the rainbow-light bus.
// Tracks the walking one-hot and reports lock, wraps and violations.
module rainbow_light_monitor
  import rainbow_light_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LOCK_STEPS = 2,
  parameter int STALL_MAX  = 0,
  parameter int ERR_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     control,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     locked,
  output logic                     wrap,
  output logic                     err,
  output logic [ERR_W-1:0]         err_count
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_STEPS + 1);
  localparam int SW = $clog2(STALL_MAX + 2);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic [PW-1:0]    din_idx;
  logic             din_oh;
  logic             step_ok;

  onehot_to_bin #(.WIDTH(WIDTH)) u_pos (
    .oh_i  (din),
    .bin_o (din_idx)
  );

  assign din_oh  = is_onehot(MAX_W'(din));
  assign step_ok = rotl1(MAX_W'(prev_q), WIDTH) == MAX_W'(din);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stall_q  <= '0;
      prev_q   <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      prev_q   <= prev_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      locked_q <= locked_d;
      ecnt_q   <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = '0;
    prev_d  = prev_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (!control) begin
      // Disabling the pattern overrides any violation on the same cycle.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (din_oh) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
            prev_d  = din;
            pos_d   = din_idx;
          end
        end
        ST_ACQUIRE: begin
          if (step_ok) begin
            prev_d = din;
            pos_d  = din_idx;
            if (cnt_q == CW'(LOCK_STEPS - 1)) begin
              state_d = ST_TRACK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (din_oh) begin
            cnt_d  = '0;
            prev_d = din;
            pos_d  = din_idx;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_TRACK: begin
          if (step_ok) begin
            prev_d = din;
            pos_d  = din_idx;
            wrap_d = prev_q[WIDTH-1];
          end else if (din == prev_q) begin
            if (stall_q == SW'(STALL_MAX)) begin
              err_d   = 1'b1;
              state_d = ST_ACQUIRE;
              cnt_d   = '0;
            end else begin
              stall_d = stall_q + SW'(1);
            end
          end else begin
            err_d = 1'b1;
            cnt_d = '0;
            if (din_oh) begin
              state_d = ST_ACQUIRE;
              prev_d  = din;
              pos_d   = din_idx;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    locked_d = (state_d == ST_TRACK);
    ecnt_d   = ecnt_q;
    if (err_d && (ecnt_q != '1)) ecnt_d = ecnt_q + ERR_W'(1);
  end

  assign pos       = pos_q;
  assign locked    = locked_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_rainbow_light_monitor.sv
// Directed bench for rainbow_light_monitor.
// A narrow error counter exposes saturation.
module tb_rainbow_light_monitor;
  import rainbow_light_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       control;
  logic [7:0] din;
  logic [2:0] pos;
  logic       locked;
  logic       wrap;
  logic       err;
  logic [1:0] err_count;

  int total  = 0;
  int fails  = 0;
  int npulse = 0;

  rainbow_light_monitor #(
    .WIDTH(8), .LOCK_STEPS(2), .STALL_MAX(0), .ERR_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .control   (control),
    .din       (din),
    .pos       (pos),
    .locked    (locked),
    .wrap      (wrap),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic [7:0] d);
    @(negedge clk);
    control = c;
    din     = d;
    @(posedge clk);
    #1;
    if (err) npulse++;
  endtask

  // p < 0 skips the pos check
  task automatic look(input string tag, input int p,
                      input logic lk, input logic w,
                      input logic e, input int ec);
    if (p >= 0) chk({tag, ".pos"}, 32'(pos), p);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".ecnt"}, 32'(err_count), ec);
  endtask

  task automatic st(input string tag, input state_t s);
    chk({tag, ".state"}, 32'(dut.state_q), 32'(s));
  endtask

  task automatic lock3(input string tag, input int ec);
    step(1'b1, 8'h01); look({tag, "a"}, 0, 1'b0, 1'b0, 1'b0, ec);
    step(1'b1, 8'h02); look({tag, "b"}, 1, 1'b0, 1'b0, 1'b0, ec);
    step(1'b1, 8'h04); look({tag, "c"}, 2, 1'b1, 1'b0, 1'b0, ec);
  endtask

  initial begin
    rst     = 1'b0;
    control = 1'b0;
    din     = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    look("rst", 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h55);
    st("idle0", ST_IDLE);
    look("idle0", 0, 1'b0, 1'b0, 1'b0, 0);

    step(1'b1, 8'h01); look("acq01", 0, 1'b0, 1'b0, 1'b0, 0);
    st("acq01", ST_ACQUIRE);
    step(1'b1, 8'h02); look("acq02", 1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 8'h04); look("lock04", 2, 1'b1, 1'b0, 1'b0, 0);
    st("lock04", ST_TRACK);
    step(1'b1, 8'h08); look("trk08", 3, 1'b1, 1'b0, 1'b0, 0);

    step(1'b1, 8'h10); look("trk10", 4, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h20); look("trk20", 5, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h40); look("trk40", 6, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h80); look("trk80", 7, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h01); look("wrap01", 0, 1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 8'h02); look("post02", 1, 1'b1, 1'b0, 1'b0, 0);

    step(1'b1, 8'h08); look("skip08", -1, 1'b0, 1'b0, 1'b1, 1);
    st("skip08", ST_ACQUIRE);
    step(1'b1, 8'h10); look("re10", 4, 1'b0, 1'b0, 1'b0, 1);
    step(1'b1, 8'h20); look("re20", 5, 1'b1, 1'b0, 1'b0, 1);

    step(1'b0, 8'h00); look("off", 5, 1'b0, 1'b0, 1'b0, 1);
    st("off", ST_IDLE);
    lock3("l5", 1);
    step(1'b1, 8'h04); look("stall", 2, 1'b0, 1'b0, 1'b1, 2);
    st("stall", ST_ACQUIRE);
    step(1'b0, 8'h00);
    lock3("l5b", 2);
    step(1'b0, 8'h04); look("stall_off", 2, 1'b0, 1'b0, 1'b0, 2);
    st("stall_off", ST_IDLE);

    @(negedge clk);
    rst = 1'b0;
    #2;
    look("rst2", 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    npulse = 0;
    lock3("l6a", 0);
    step(1'b1, 8'h00); look("v1", 2, 1'b0, 1'b0, 1'b1, 1);
    st("v1", ST_IDLE);
    lock3("l6b", 1);
    step(1'b1, 8'h03); look("v2", 2, 1'b0, 1'b0, 1'b1, 2);
    lock3("l6c", 2);
    step(1'b1, 8'h10); look("v3", -1, 1'b0, 1'b0, 1'b1, 3);
    step(1'b1, 8'h20); look("v3a", 5, 1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 8'h40); look("v3b", 6, 1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 8'h40); look("v4", 6, 1'b0, 1'b0, 1'b1, 3);
    step(1'b1, 8'h80); look("v4a", 7, 1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 8'h01); look("v4b", 0, 1'b1, 1'b0, 1'b0, 3);
    chk("npulse", 32'(npulse), 4);

    #2;
    rst = 1'b0;
    #1;
    look("async", 0, 1'b0, 1'b0, 1'b0, 0);
    st("async", ST_IDLE);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
